// File: rtl/btb_port_scheduler_pkg.sv
// rtl/btb_port_scheduler_pkg.sv - shared BTB field widths, entry slices and scheduler state encoding
package btb_port_scheduler_pkg;

  localparam int BTB_INDEX_W = 9;
  localparam int BTB_TAG_W   = 12;
  localparam int BTB_TYP_W   = 2;
  localparam int BTB_TAR_W   = 32;
  localparam int BTB_ENTRY_W = 1 + BTB_TAG_W + BTB_TYP_W + BTB_TAR_W;
  localparam int BTB_ENTRIES = 1 << BTB_INDEX_W;

  // Entry layout: {valid, tag, typ, tar}, shared with the array read side.
  localparam int BTB_VALID_BIT = BTB_ENTRY_W - 1;
  localparam int BTB_TAG_HI    = BTB_VALID_BIT - 1;
  localparam int BTB_TAG_LO    = BTB_TAG_HI - BTB_TAG_W + 1;
  localparam int BTB_TYP_HI    = BTB_TAG_LO - 1;
  localparam int BTB_TYP_LO    = BTB_TAR_W;
  localparam int BTB_TAR_HI    = BTB_TAR_W - 1;
  localparam int BTB_TAR_LO    = 0;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } sched_state_e;

  function automatic logic [BTB_ENTRY_W-1:0] btb_entry_pack(
    input logic [BTB_TAG_W-1:0] tag,
    input logic [BTB_TYP_W-1:0] typ,
    input logic [BTB_TAR_W-1:0] tar
  );
    logic [BTB_ENTRY_W-1:0] e;
    e = '0;
    e[BTB_VALID_BIT]          = 1'b1;
    e[BTB_TAG_HI:BTB_TAG_LO]  = tag;
    e[BTB_TYP_HI:BTB_TYP_LO]  = typ;
    e[BTB_TAR_HI:BTB_TAR_LO]  = tar;
    return e;
  endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// rtl/btb_upd_fifo.sv - small update FIFO with synchronous flush and async reset
module btb_upd_fifo #(
  parameter int WIDTH = 55,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W:0]   r_wptr;
  logic [PTR_W:0]   r_rptr;
  logic             w_push;
  logic             w_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                   (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
  assign o_head  = r_mem[r_rptr[PTR_W-1:0]];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wptr[PTR_W-1:0]] <= i_data;
  end

endmodule

// File: rtl/btb_port_scheduler.sv
// rtl/btb_port_scheduler.sv - arbitrates the single BTB port between fetch lookups, queued updates and the invalidation sweep
module btb_port_scheduler
  import btb_port_scheduler_pkg::*;
#(
  parameter int INDEX_W      = BTB_INDEX_W,
  parameter int TAG_W        = BTB_TAG_W,
  parameter int TYP_W        = BTB_TYP_W,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   lookup_req,
  input  logic [INDEX_W-1:0]     lookup_index,
  output logic                   lookup_grant,
  output logic                   fetch_stall_req,
  input  logic                   upd_valid,
  output logic                   upd_ready,
  input  logic [INDEX_W-1:0]     upd_index,
  input  logic [TAG_W-1:0]       upd_tag,
  input  logic [TYP_W-1:0]       upd_typ,
  input  logic [31:0]            upd_tar,
  input  logic                   inv_all,
  output logic                   btb_en,
  output logic                   btb_we,
  output logic [INDEX_W-1:0]     btb_addr,
  output logic [BTB_ENTRY_W-1:0] btb_wdata,
  output logic                   init_busy
);

  localparam int FIFO_W = INDEX_W + TAG_W + TYP_W + 32;
  localparam int AGE_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

  sched_state_e       r_state;
  sched_state_e       w_state_nxt;
  logic [INDEX_W-1:0] r_cnt;
  logic [INDEX_W-1:0] w_cnt_nxt;
  logic [AGE_W-1:0]   r_age;
  logic [AGE_W-1:0]   w_age_nxt;

  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               w_steal;
  logic               w_en;
  logic               w_we;
  logic [FIFO_W-1:0]  w_head;
  logic [FIFO_W-1:0]  w_upd_data;
  logic [INDEX_W-1:0] w_head_index;
  logic [TAG_W-1:0]   w_head_tag;
  logic [TYP_W-1:0]   w_head_typ;
  logic [31:0]        w_head_tar;

  assign w_upd_data = {upd_index, upd_tag, upd_typ, upd_tar};
  assign {w_head_index, w_head_tag, w_head_typ, w_head_tar} = w_head;
  assign w_push     = upd_valid && upd_ready;
  assign w_steal    = !w_empty && ((r_age == AGE_MAX) || w_full);

  btb_upd_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_flush (inv_all),
    .i_push  (w_push),
    .i_data  (w_upd_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
      r_age   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_age   <= w_age_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_en            = 1'b0;
    w_we            = 1'b0;
    w_pop           = 1'b0;
    btb_addr        = '0;
    btb_wdata       = '0;
    lookup_grant    = 1'b0;
    fetch_stall_req = 1'b0;
    upd_ready       = 1'b0;
    init_busy       = (r_state == ST_INIT);

    if (inv_all) begin
      // Port is idle this cycle; the sweep starts fresh next cycle.
      fetch_stall_req = 1'b1;
      w_state_nxt     = ST_INIT;
      w_cnt_nxt       = '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          w_en            = 1'b1;
          w_we            = 1'b1;
          btb_addr        = r_cnt;
          fetch_stall_req = 1'b1;
          w_cnt_nxt       = r_cnt + 1'b1;
          if (r_cnt == '1) w_state_nxt = ST_RUN;
        end
        ST_RUN: begin
          upd_ready = !w_full;
          if (w_steal) begin
            w_en            = 1'b1;
            w_we            = 1'b1;
            w_pop           = 1'b1;
            btb_addr        = w_head_index;
            btb_wdata       = btb_entry_pack(w_head_tag, w_head_typ, w_head_tar);
            fetch_stall_req = 1'b1;
          end else if (lookup_req) begin
            w_en         = 1'b1;
            btb_addr     = lookup_index;
            lookup_grant = 1'b1;
          end else if (!w_empty) begin
            w_en      = 1'b1;
            w_we      = 1'b1;
            w_pop     = 1'b1;
            btb_addr  = w_head_index;
            btb_wdata = btb_entry_pack(w_head_tag, w_head_typ, w_head_tar);
          end
        end
        default: w_state_nxt = ST_INIT;
      endcase
    end
  end

  // Age tracks how long the current head has waited for the port.
  always_comb begin
    w_age_nxt = r_age;
    if (inv_all || w_empty || w_pop) begin
      w_age_nxt = '0;
    end else if (r_age != AGE_MAX) begin
      w_age_nxt = r_age + 1'b1;
    end
  end

  assign btb_en = w_en && resetn;
  assign btb_we = w_we && resetn;

endmodule
